otter_cu_fsm: RTL and testbench

- Multi-cycle sequencing state machine for the OTTER MCU control unit.
- Works alongside the combinational instruction decoder. The decoder selects datapath muxes and ALU function; this block decides in which cycle PC, register file, data memory and CSRs are written.
- Also latches and services external interrupts. Its int_taken output feeds the decoder's int_taken input so the PC mux selects the trap vector.

---
 rtl/otter_cu_fsm_if.sv | 28 ++
 rtl/otter_cu_fsm.sv | 136 +++++++++++++
 tb/tb_otter_cu_fsm.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/otter_cu_fsm_if.sv
// Control-unit handshake bundle: decoder-side fields in, datapath strobes out.
interface otter_cu_fsm_if;
  logic [6:0] ir6_0;
  logic [2:0] ir14_12;
  logic       intr;
  logic       csr_mie;
  logic       PCWrite;
  logic       regWrite;
  logic       memWE2;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       reset;
  logic       csr_WE;
  logic       int_taken;
  logic       mret_exec;

  modport slave (
    input  ir6_0, ir14_12, intr, csr_mie,
    output PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset, csr_WE, int_taken, mret_exec
  );

  modport master (
    output ir6_0, ir14_12, intr, csr_mie,
    input  PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
           reset, csr_WE, int_taken, mret_exec
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER multi-cycle sequencer: decides the cycle in which PC, regfile, data
// memory and CSRs are written, and latches/services external interrupts.
module otter_cu_fsm #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  otter_cu_fsm_if.slave bus
);
  localparam int unsigned CNT_W = 3;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [2:0] {INIT, FETCH, EXEC, WB, INTR} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             intr_pend, pend_nx;
  logic             intr_take;

  logic pc_we, rf_we, dm_we, im_rd, dm_rd, dp_rst, csr_we, int_tk, mret;

  // Pulses are captured here; servicing the trap drops the request.
  assign pend_nx   = (state == INTR) ? 1'b0 : (intr_pend | bus.intr);
  assign intr_take = (intr_pend | bus.intr) & bus.csr_mie;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= INIT;
      cnt       <= '0;
      intr_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      intr_pend <= pend_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    dm_we    = 1'b0;
    im_rd    = 1'b0;
    dm_rd    = 1'b0;
    dp_rst   = 1'b0;
    csr_we   = 1'b0;
    int_tk   = 1'b0;
    mret     = 1'b0;

    case (state)
      INIT: begin
        dp_rst   = 1'b1;
        state_nx = FETCH;
      end
      FETCH: begin
        im_rd    = 1'b1;
        state_nx = EXEC;
      end
      EXEC: begin
        state_nx = intr_take ? INTR : FETCH;
        case (bus.ir6_0)
          OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            pc_we = 1'b1;
            rf_we = 1'b1;
          end
          OP_STORE: begin
            pc_we = 1'b1;
            dm_we = 1'b1;
          end
          OP_LOAD: begin
            dm_rd    = 1'b1;
            cnt_nx   = CNT_W'(MEM_LAT - 1);
            state_nx = WB;
          end
          OP_SYS: begin
            pc_we = 1'b1;
            case (bus.ir14_12)
              3'b000:                 mret = 1'b1;
              3'b001, 3'b010, 3'b011: begin
                rf_we  = 1'b1;
                csr_we = 1'b1;
              end
              default: ;
            endcase
          end
          default: pc_we = 1'b1;
        endcase
      end
      WB: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else begin
          pc_we    = 1'b1;
          rf_we    = 1'b1;
          state_nx = intr_take ? INTR : FETCH;
        end
      end
      INTR: begin
        int_tk   = 1'b1;
        pc_we    = 1'b1;
        state_nx = FETCH;
      end
      default: state_nx = INIT;
    endcase

    // A reset landing mid-instruction must not commit any architectural write.
    if (RST) begin
      pc_we  = 1'b0;
      rf_we  = 1'b0;
      dm_we  = 1'b0;
      dm_rd  = 1'b0;
      csr_we = 1'b0;
    end
  end

  assign bus.PCWrite   = pc_we;
  assign bus.regWrite  = rf_we;
  assign bus.memWE2    = dm_we;
  assign bus.memRDEN1  = im_rd;
  assign bus.memRDEN2  = dm_rd;
  assign bus.reset     = dp_rst;
  assign bus.csr_WE    = csr_we;
  assign bus.int_taken = int_tk;
  assign bus.mret_exec = mret;
endmodule

// File: tb/tb_otter_cu_fsm.sv
// Scoreboard bench for otter_cu_fsm (MEM_LAT=3): driver queues the expected
// strobe vector per cycle, a negedge monitor pops and compares.
module tb_otter_cu_fsm;
  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] SYS = 7'b1110011;
  localparam logic [6:0] ILL = 7'b1111111;

  // {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken, mret_exec}
  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_INIT  = 9'b000001000;
  localparam logic [8:0] O_FETCH = 9'b000100000;
  localparam logic [8:0] O_ALU   = 9'b110000000;
  localparam logic [8:0] O_PC    = 9'b100000000;
  localparam logic [8:0] O_ST    = 9'b101000000;
  localparam logic [8:0] O_LD    = 9'b000010000;
  localparam logic [8:0] O_INT   = 9'b100000010;
  localparam logic [8:0] O_CSR   = 9'b110000100;
  localparam logic [8:0] O_MRET  = 9'b100000001;

  typedef struct {
    int         id;
    logic [8:0] exp;
  } entry_t;

  logic   clk = 1'b0;
  logic   rst;
  entry_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     step_no = 0;
  logic   stop_req = 1'b0;

  otter_cu_fsm_if bus();

  otter_cu_fsm #(.MEM_LAT(3)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic [6:0] op, input logic [2:0] f3,
                      input logic ir_q, input logic mie, input logic [8:0] exp);
    entry_t e;
    @(posedge clk);
    #1;
    rst         = r;
    bus.ir6_0   = op;
    bus.ir14_12 = f3;
    bus.intr    = ir_q;
    bus.csr_mie = mie;
    step_no++;
    e.id  = step_no;
    e.exp = exp;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [8:0] act;
    entry_t     e;
    act = {bus.PCWrite, bus.regWrite, bus.memWE2, bus.memRDEN1, bus.memRDEN2,
           bus.reset, bus.csr_WE, bus.int_taken, bus.mret_exec};
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL cycle%0d outputs: got %b expected %b", e.id, act, e.exp);
      end
      if (bus.int_taken === 1'b1 && bus.PCWrite !== 1'b1) begin
        errors++;
        $display("FAIL cycle%0d int_taken without PCWrite: got %b expected 1", e.id, bus.PCWrite);
      end
      if (bus.reset === 1'b1 && {bus.PCWrite, bus.regWrite, bus.memWE2, bus.csr_WE} !== 4'b0000) begin
        errors++;
        $display("FAIL cycle%0d write strobe during INIT: got %b expected 0000", e.id,
                 {bus.PCWrite, bus.regWrite, bus.memWE2, bus.csr_WE});
      end
    end else if (stop_req) begin
      if (errors == 0 && checks >= 12)
        $display("PASS");
      else
        $display("FAIL summary: got %0d errors over %0d checks, expected 0 errors", errors, checks);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    rst         = 1'b1;
    bus.ir6_0   = 7'd0;
    bus.ir14_12 = 3'd0;
    bus.intr    = 1'b0;
    bus.csr_mie = 1'b0;

    // reset for two cycles, then ADD loop
    step(1, ADD, 3'd0, 0, 0, O_INIT);
    step(0, ADD, 3'd0, 0, 0, O_INIT);
    step(0, ADD, 3'd0, 0, 0, O_FETCH);
    step(0, ADD, 3'd0, 0, 0, O_ALU);
    step(0, ADD, 3'd0, 0, 0, O_FETCH);
    step(0, ADD, 3'd0, 0, 0, O_ALU);
    // LW with three WB cycles
    step(0, LW,  3'd2, 0, 0, O_FETCH);
    step(0, LW,  3'd2, 0, 0, O_LD);
    step(0, LW,  3'd2, 0, 0, O_NONE);
    step(0, LW,  3'd2, 0, 0, O_NONE);
    step(0, LW,  3'd2, 0, 0, O_ALU);
    // SW with one-cycle intr pulse during FETCH
    step(0, SW,  3'd2, 1, 1, O_FETCH);
    step(0, SW,  3'd2, 0, 1, O_ST);
    step(0, SW,  3'd2, 0, 1, O_INT);
    step(0, ADD, 3'd0, 0, 1, O_FETCH);
    step(0, ADD, 3'd0, 0, 1, O_ALU);
    // intr held with mie=0 across three ADDs
    step(0, ADD, 3'd0, 1, 0, O_FETCH);
    step(0, ADD, 3'd0, 1, 0, O_ALU);
    step(0, ADD, 3'd0, 1, 0, O_FETCH);
    step(0, ADD, 3'd0, 1, 0, O_ALU);
    step(0, ADD, 3'd0, 1, 0, O_FETCH);
    step(0, ADD, 3'd0, 1, 0, O_ALU);
    // enable: pending request taken after next completing EXEC
    step(0, ADD, 3'd0, 0, 1, O_FETCH);
    step(0, ADD, 3'd0, 0, 1, O_ALU);
    step(0, ADD, 3'd0, 0, 1, O_INT);
    // CSRRW
    step(0, SYS, 3'd1, 0, 1, O_FETCH);
    step(0, SYS, 3'd1, 0, 1, O_CSR);
    // MRET with simultaneous interrupt: MRET first, then INTR
    step(0, SYS, 3'd0, 1, 1, O_FETCH);
    step(0, SYS, 3'd0, 1, 1, O_MRET);
    step(0, BEQ, 3'd0, 0, 1, O_INT);
    // branch, illegal opcode, other system funct3
    step(0, BEQ, 3'd0, 0, 1, O_FETCH);
    step(0, BEQ, 3'd0, 0, 1, O_PC);
    step(0, ILL, 3'd0, 0, 1, O_FETCH);
    step(0, ILL, 3'd0, 0, 1, O_PC);
    step(0, SYS, 3'd4, 0, 1, O_FETCH);
    step(0, SYS, 3'd4, 0, 1, O_PC);
    // reset in middle WB cycle of a load
    step(0, LW,  3'd2, 0, 1, O_FETCH);
    step(0, LW,  3'd2, 0, 1, O_LD);
    step(0, LW,  3'd2, 0, 1, O_NONE);
    step(1, LW,  3'd2, 0, 1, O_NONE);
    step(0, LW,  3'd2, 0, 1, O_INIT);
    // reset in final WB cycle: write strobes forced low
    step(0, LW,  3'd2, 0, 1, O_FETCH);
    step(0, LW,  3'd2, 0, 1, O_LD);
    step(0, LW,  3'd2, 0, 1, O_NONE);
    step(0, LW,  3'd2, 0, 1, O_NONE);
    step(1, LW,  3'd2, 0, 1, O_NONE);
    step(0, JAL, 3'd0, 0, 1, O_INIT);
    step(0, JAL, 3'd0, 0, 1, O_FETCH);
    step(0, JAL, 3'd0, 0, 1, O_ALU);
    step(0, JAL, 3'd0, 0, 1, O_FETCH);

    stop_req = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL drain timeout: %0d entries left, expected 0", exp_q.size());
    $fatal(1, "scoreboard did not drain");
  end
endmodule
